// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Provides the 3-bit operation encodings used by the top-level mode port and
// by the barrel shifter's op input.
package shift_reg_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHL  = 3'b001;
    localparam mode_t MODE_SHR  = 3'b010;
    localparam mode_t MODE_ROL  = 3'b011;
    localparam mode_t MODE_ROR  = 3'b100;
    localparam mode_t MODE_ASR  = 3'b101;
    localparam mode_t MODE_LOAD = 3'b110;
    localparam mode_t MODE_SER  = 3'b111;

endpackage

// File: rtl/shift_reg_barrel.sv
// Combinational multi-bit shifter/rotator.
// Ports:
//   data     - current register value
//   k        - shift amount (already clamped by the caller)
//   op       - MODE_SHL/SHR/ROL/ROR/ASR; anything else passes data through
//   fill     - fill bit for logical shifts
//   next     - shifted/rotated value
//   out_bit  - last bit shifted or rotated out (meaningless when k == 0)
module shift_reg_barrel
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    k,
    input  mode_t            op,
    input  logic             fill,
    output logic [WIDTH-1:0] next,
    output logic             out_bit
);

    int unsigned      ki;
    logic [WIDTH-1:0] lo_mask;   // low k bits set
    logic [WIDTH-1:0] hi_mask;   // high k bits set
    logic [WIDTH-1:0] left_out;  // bit 0 holds data[WIDTH-k]
    logic [WIDTH-1:0] right_out; // bit 0 holds data[k-1]

    always_comb begin
        ki        = 32'(k);
        lo_mask   = ~({WIDTH{1'b1}} << k);
        hi_mask   = ~({WIDTH{1'b1}} >> k);
        left_out  = data >> (WIDTH - ki);
        right_out = (ki == 0) ? '0 : (data >> (ki - 1));
        next      = data;
        out_bit   = 1'b0;
        unique case (op)
            MODE_SHL: begin
                next    = (data << k) | ({WIDTH{fill}} & lo_mask);
                out_bit = left_out[0];
            end
            MODE_SHR: begin
                next    = (data >> k) | ({WIDTH{fill}} & hi_mask);
                out_bit = right_out[0];
            end
            MODE_ROL: begin
                next    = (data << k) | (data >> (WIDTH - ki));
                out_bit = left_out[0];
            end
            MODE_ROR: begin
                next    = (data >> k) | (data << (WIDTH - ki));
                out_bit = right_out[0];
            end
            MODE_ASR: begin
                next    = (data >> k) | ({WIDTH{data[WIDTH-1]}} & hi_mask);
                out_bit = right_out[0];
            end
            default: begin
                next    = data;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with a built-in serializer.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   en         - clock enable (done still self-clears when low)
//   mode       - operation select (shift_reg_pkg MODE_*)
//   amt        - shift/rotate amount, clamped to MAX_SHIFT
//   prl_in     - parallel load data
//   srl_in     - serial fill / capture bit
//   msb_first  - serializer direction, latched at SER
//   out        - register contents
//   srl_out    - last bit shifted or rotated out
//   busy       - serializer active
//   done       - one-cycle pulse at serializer completion
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned MAX_SHIFT = WIDTH - 1,
    localparam int unsigned AW        = $clog2(MAX_SHIFT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] prl_in,
    input  logic             srl_in,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out,
    output logic             srl_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [AW-1:0]  MAX_K    = AW'(MAX_SHIFT);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             srl_q, srl_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             msb_q, msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [AW-1:0]    k_clamp;
    logic [AW-1:0]    bar_k;
    mode_t            bar_op;
    logic [WIDTH-1:0] bar_next;
    logic             bar_bit;

    assign k_clamp = (amt > MAX_K) ? MAX_K : amt;

    // The serializer reuses the barrel with a single-bit shift toward the output end.
    always_comb begin
        bar_k  = k_clamp;
        bar_op = mode;
        if (busy_q) begin
            bar_k  = AW'(1);
            bar_op = msb_q ? MODE_SHL : MODE_SHR;
        end
    end

    shift_reg_barrel #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_barrel (
        .data    (out_q),
        .k       (bar_k),
        .op      (bar_op),
        .fill    (srl_in),
        .next    (bar_next),
        .out_bit (bar_bit)
    );

    always_comb begin
        out_d  = out_q;
        srl_d  = srl_q;
        busy_d = busy_q;
        done_d = 1'b0;
        msb_d  = msb_q;
        cnt_d  = cnt_q;
        if (en) begin
            if (busy_q) begin
                out_d = bar_next;
                srl_d = bar_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end else begin
                unique case (mode)
                    MODE_HOLD: ;
                    MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: begin
                        if (k_clamp != '0) begin
                            out_d = bar_next;
                            srl_d = bar_bit;
                        end
                    end
                    MODE_LOAD: out_d = prl_in;
                    MODE_SER: begin
                        out_d  = prl_in;
                        busy_d = 1'b1;
                        cnt_d  = '0;
                        msb_d  = msb_first;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            srl_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            msb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            srl_q  <= srl_d;
            busy_q <= busy_d;
            done_q <= done_d;
            msb_q  <= msb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out     = out_q;
    assign srl_out = srl_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: table-driven single-cycle ops plus
// hand-written serializer, stall, reset-abort and clamp sequences.
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, srl_in, msb_first;
    logic [2:0] mode, amt;
    logic [7:0] prl_in;
    logic [7:0] out;
    logic       srl_out, busy, done;

    // Second instance with MAX_SHIFT=5 for amount clamping.
    logic [2:0] mode2, amt2;
    logic [7:0] prl2, out2;
    logic       srl2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .amt(amt), .prl_in(prl_in),
        .srl_in(srl_in), .msb_first(msb_first), .out(out), .srl_out(srl_out),
        .busy(busy), .done(done)
    );

    shift_reg_univ #(.WIDTH(8), .MAX_SHIFT(5)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode2), .amt(amt2), .prl_in(prl2),
        .srl_in(srl_in), .msb_first(msb_first), .out(out2), .srl_out(srl2),
        .busy(busy2), .done(done2)
    );

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [2:0] amt;
        logic [7:0] prl;
        logic       fill;
        logic [7:0] exp_out;
        logic       exp_srl;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Serializer run. stall_mask bit e drops en on the e-th edge after SER.
    task automatic ser_run(input string tag, input logic [7:0] data, input logic msb,
                           input logic [7:0] pat, input logic [15:0] stall_mask,
                           input logic [2:0] gmode, input logic [7:0] gprl);
        int         s;
        int         e;
        logic [7:0] tmp;
        logic [7:0] exp_out;
        logic       last_srl;
        en = 1'b1; mode = MODE_SER; prl_in = data; msb_first = msb;
        step;
        check({tag, " start busy"}, 32'(busy), 32'd1);
        check({tag, " start out"}, 32'(out), 32'(data));
        // Requests made while busy must be ignored.
        mode = gmode; prl_in = gprl; msb_first = ~msb; amt = 3'd3;
        s = 0;
        e = 1;
        last_srl = srl_out;
        while (s < 8 && e < 40) begin
            en = !stall_mask[e];
            if (en) srl_in = pat[s];
            step;
            if (en) begin
                s++;
                tmp = msb ? (data >> (8 - s)) : (data >> (s - 1));
                last_srl = tmp[0];
                check({tag, " srl_out"}, 32'(srl_out), 32'(last_srl));
                check({tag, " busy"}, 32'(busy), 32'(s < 8));
                check({tag, " done"}, 32'(done), 32'(s == 8));
            end else begin
                check({tag, " stall srl_out"}, 32'(srl_out), 32'(last_srl));
                check({tag, " stall busy"}, 32'(busy), 32'd1);
                check({tag, " stall done"}, 32'(done), 32'd0);
            end
            e++;
        end
        check({tag, " shift count"}, 32'(s), 32'd8);
        for (int i = 0; i < 8; i++) exp_out[i] = msb ? pat[7 - i] : pat[i];
        check({tag, " captured out"}, 32'(out), 32'(exp_out));
        en = 1'b1; mode = MODE_HOLD;
        step;
        check({tag, " done cleared"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; amt = '0; prl_in = '0;
        srl_in = 1'b0; msb_first = 1'b0; mode2 = MODE_HOLD; amt2 = '0; prl2 = '0;

        //          en    mode       amt   prl    fill  exp_out exp_srl
        vecs[0]  = '{1'b1, MODE_LOAD, 3'd0, 8'hB4, 1'b0, 8'hB4, 1'b0};
        vecs[1]  = '{1'b1, MODE_SHL,  3'd3, 8'h00, 1'b1, 8'hA7, 1'b1};
        vecs[2]  = '{1'b1, MODE_LOAD, 3'd0, 8'hB4, 1'b0, 8'hB4, 1'b1};
        vecs[3]  = '{1'b1, MODE_ASR,  3'd2, 8'h00, 1'b0, 8'hED, 1'b0};
        vecs[4]  = '{1'b1, MODE_LOAD, 3'd0, 8'hB4, 1'b0, 8'hB4, 1'b0};
        vecs[5]  = '{1'b1, MODE_ROR,  3'd4, 8'h00, 1'b1, 8'h4B, 1'b0};
        vecs[6]  = '{1'b1, MODE_ROL,  3'd2, 8'h00, 1'b0, 8'h2D, 1'b1};
        vecs[7]  = '{1'b1, MODE_SHR,  3'd0, 8'h00, 1'b0, 8'h2D, 1'b1};
        vecs[8]  = '{1'b1, MODE_HOLD, 3'd5, 8'h77, 1'b0, 8'h2D, 1'b1};
        vecs[9]  = '{1'b1, MODE_SHR,  3'd3, 8'h00, 1'b0, 8'h05, 1'b1};
        vecs[10] = '{1'b1, MODE_SHL,  3'd7, 8'h00, 1'b0, 8'h80, 1'b0};
        vecs[11] = '{1'b1, MODE_ASR,  3'd7, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[12] = '{1'b1, MODE_SHL,  3'd0, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[13] = '{1'b0, MODE_LOAD, 3'd0, 8'h12, 1'b0, 8'hFF, 1'b0};
        vecs[14] = '{1'b1, MODE_ROR,  3'd1, 8'h00, 1'b0, 8'hFF, 1'b1};

        step;
        step;
        rst = 1'b0;
        check("reset out", 32'(out), 32'd0);
        check("reset srl_out", 32'(srl_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);

        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; amt = vecs[i].amt;
            prl_in = vecs[i].prl; srl_in = vecs[i].fill;
            step;
            check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d srl_out", i), 32'(srl_out), 32'(vecs[i].exp_srl));
        end

        // LSB-first, constant srl_in=1, a new SER request while busy.
        ser_run("ser_lsb", 8'hA5, 1'b0, 8'hFF, 16'h0000, MODE_SER, 8'h3C);
        // 3-cycle stall mid-stream with a LOAD of 0x00 while busy.
        ser_run("ser_stall", 8'hA5, 1'b0, 8'h1D, 16'h0070, MODE_LOAD, 8'h00);
        // MSB-first capture comes out bit-reversed.
        ser_run("ser_msb", 8'h6C, 1'b1, 8'h1D, 16'h0000, MODE_ROL, 8'hFF);

        // Reset on the 4th serialized bit aborts the stream.
        en = 1'b1; mode = MODE_SER; prl_in = 8'hA5; msb_first = 1'b0; srl_in = 1'b1;
        step;
        mode = MODE_HOLD;
        for (int i = 0; i < 3; i++) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("abort out", 32'(out), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort srl_out", 32'(srl_out), 32'd0);
        ser_run("ser_after_rst", 8'h5A, 1'b0, 8'hC3, 16'h0000, MODE_HOLD, 8'h00);

        // Clamping on the MAX_SHIFT=5 instance.
        en = 1'b1; mode = MODE_HOLD; mode2 = MODE_LOAD; prl2 = 8'hFF;
        step;
        check("clamp load", 32'(out2), 32'hFF);
        mode2 = MODE_SHR; amt2 = 3'b111; srl_in = 1'b0;
        step;
        check("clamp shr out", 32'(out2), 32'h07);
        check("clamp shr srl_out", 32'(srl2), 32'd1);
        mode2 = MODE_ROL; amt2 = 3'd0;
        step;
        check("clamp k0 out", 32'(out2), 32'h07);
        check("clamp k0 srl_out", 32'(srl2), 32'd1);
        check("dut2 busy", 32'(busy2), 32'd0);
        check("dut2 done", 32'(done2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
